// File: rtl/sysarr_pkg.sv
// Shared types and sizing helpers for the systolic-array scheduler,
// input feeder and result collector.
package sysarr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DRAIN
  } collect_state_t;

  function automatic int ptr_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int row_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/col_write_ctr.sv
// Per-column saturating write pointer for the result bank,
// with write enable and a sticky overflow flag.
module col_write_ctr
  import sysarr_pkg::*;
#(
  parameter int N  = 2,
  parameter int PW = ptr_width(N),
  parameter int RW = row_width(N)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          en,
  input  logic          valid,
  output logic [RW-1:0] waddr,
  output logic          we,
  output logic          full_nxt,
  output logic          ovf
);

  logic [PW-1:0] ptr;
  logic          full;

  assign full     = (ptr == PW'(N));
  assign we       = en & valid & ~full;
  assign waddr    = ptr[RW-1:0];
  // The pointer is N on the next edge if it is already N or this write fills it.
  assign full_nxt = full | (we & (ptr == PW'(N - 1)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      ptr <= '0;
      ovf <= 1'b0;
    end else begin
      if (we)
        ptr <= ptr + 1'b1;
      if (en & valid & full)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Reassembles skewed per-column results into an NxN bank and
// streams it out row by row over valid/ready.
module result_collector
  import sysarr_pkg::*;
#(
  parameter int MATRIX_SIZE = 2,
  parameter int DATA_SIZE   = 32
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             start,
  input  logic [MATRIX_SIZE-1:0]           col_valid,
  input  logic [MATRIX_SIZE*DATA_SIZE-1:0] col_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [MATRIX_SIZE*DATA_SIZE-1:0] out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done,
  output logic                             overflow
);

  localparam int N  = MATRIX_SIZE;
  localparam int D  = DATA_SIZE;
  localparam int PW = ptr_width(N);
  localparam int RW = row_width(N);

  collect_state_t state_q, state_d;

  logic [RW-1:0]  row_q, row_d;
  logic           done_d;
  logic           clear;
  logic           collect;
  logic           fire;
  logic           last_row;
  logic [N-1:0]   we;
  logic [N-1:0]   full_nxt;
  logic [N-1:0]   ovf;
  logic [RW-1:0]  waddr [N];
  logic [N*D-1:0] bank  [N];

  assign clear    = (state_q == IDLE) & start;
  assign collect  = (state_q == COLLECT);
  assign last_row = (row_q == RW'(N - 1));
  assign fire     = out_valid & out_ready;

  for (genvar j = 0; j < N; j++) begin : g_col
    col_write_ctr #(
      .N  (N),
      .PW (PW),
      .RW (RW)
    ) u_ctr (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .en       (collect),
      .valid    (col_valid[j]),
      .waddr    (waddr[j]),
      .we       (we[j]),
      .full_nxt (full_nxt[j]),
      .ovf      (ovf[j])
    );
  end

  // Bank contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    for (int j = 0; j < N; j++) begin
      if (we[j])
        bank[waddr[j]][j*D +: D] <= col_data[j*D +: D];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          row_d   = '0;
        end
      end
      COLLECT: begin
        if (&full_nxt)
          state_d = DRAIN;
      end
      DRAIN: begin
        if (fire) begin
          if (last_row) begin
            state_d = IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_valid = (state_q == DRAIN);
  assign out_last  = out_valid & last_row;
  assign out_data  = out_valid ? bank[row_q] : '0;
  assign busy      = (state_q != IDLE);
  assign overflow  = |ovf;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed tiles plus randomized tiles
// checked every cycle against a queue-based model.
module tb_result_collector;

  localparam int N = 2;
  localparam int D = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [N-1:0]  col_valid = '0;
  logic [63:0]   col_data = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [63:0]   out_data;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          overflow;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  result_collector #(
    .MATRIX_SIZE (N),
    .DATA_SIZE   (D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .col_valid (col_valid),
    .col_data  (col_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Model: 0 idle, 1 collecting, 2 draining.
  int          m_mode = 0;
  int          m_row = 0;
  bit          m_ovf = 0;
  bit          m_done = 0;
  int          m_done_cnt = 0;
  logic [31:0] cols [N][$];
  logic [63:0] log_q [$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] exp_row(input int r);
    logic [63:0] v;
    v[31:0]  = cols[0][r];
    v[63:32] = cols[1][r];
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode = 0;
      m_row  = 0;
      m_ovf  = 0;
      m_done = 0;
      for (int j = 0; j < N; j++) cols[j].delete();
    end else begin
      m_done = 0;
      case (m_mode)
        0: if (start) begin
          for (int j = 0; j < N; j++) cols[j].delete();
          m_ovf  = 0;
          m_row  = 0;
          m_mode = 1;
        end
        1: begin
          for (int j = 0; j < N; j++) begin
            if (col_valid[j]) begin
              if (cols[j].size() < N)
                cols[j].push_back(col_data[j*D +: D]);
              else
                m_ovf = 1;
            end
          end
          if (cols[0].size() == N && cols[1].size() == N)
            m_mode = 2;
        end
        2: if (out_ready) begin
          log_q.push_back(exp_row(m_row));
          if (m_row == N - 1) begin
            m_mode = 0;
            m_row  = 0;
            m_done = 1;
            m_done_cnt++;
          end else begin
            m_row++;
          end
        end
        default: m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("out_valid", 64'(out_valid), 64'(m_mode == 2));
      chk("out_last", 64'(out_last),
          64'(m_mode == 2 && m_row == N - 1));
      chk("out_data", out_data,
          (m_mode == 2) ? exp_row(m_row) : 64'd0);
      chk("busy", 64'(busy), 64'(m_mode != 0));
      chk("done", 64'(done), 64'(m_done));
      chk("overflow", 64'(overflow), 64'(m_ovf));
    end
  end

  task automatic step(input logic s, input logic [1:0] cv,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic rdy);
    start     = s;
    col_valid = cv;
    col_data  = {d1, d0};
    out_ready = rdy;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(0, 2'b00, 0, 0, rdy);
  endtask

  task automatic skew_tile();
    step(1, 2'b00, 0, 0, 1);
    step(0, 2'b01, 11, 0, 1);
    step(0, 2'b11, 21, 12, 1);
    step(0, 2'b10, 0, 22, 1);
  endtask

  task automatic pin_rows(input string nm);
    chk({nm, "_nrows"}, 64'(log_q.size()), 64'd2);
    if (log_q.size() == 2) begin
      chk({nm, "_row0"}, log_q[0], {32'd12, 32'd11});
      chk({nm, "_row1"}, log_q[1], {32'd22, 32'd21});
    end
  endtask

  initial begin
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    idle(2, 0);
    chk("reset_out_data", out_data, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    idle(2, 0);

    // Skewed tile, out_ready high
    log_q.delete();
    m_done_cnt = 0;
    step(1, 2'b00, 0, 0, 1);
    step(0, 2'b01, 11, 0, 1);
    step(0, 2'b11, 21, 12, 1);
    chk("c3_no_valid", 64'(out_valid), 64'd0);
    step(0, 2'b10, 0, 22, 1);
    chk("c4_valid", 64'(out_valid), 64'd1);
    idle(4, 1);
    pin_rows("t1");
    chk("t1_done_cnt", 64'(m_done_cnt), 64'd1);

    // Backpressure during drain
    log_q.delete();
    skew_tile();
    idle(3, 0);
    chk("t2_hold", out_data, {32'd12, 32'd11});
    idle(4, 1);
    pin_rows("t2");

    // Simultaneous columns
    log_q.delete();
    step(1, 2'b00, 0, 0, 1);
    step(0, 2'b11, 11, 12, 1);
    step(0, 2'b11, 21, 22, 1);
    chk("t3_valid", 64'(out_valid), 64'd1);
    idle(3, 1);
    pin_rows("t3");

    // Overflow on col0
    log_q.delete();
    step(1, 2'b00, 0, 0, 1);
    step(0, 2'b01, 11, 0, 1);
    step(0, 2'b01, 21, 0, 1);
    step(0, 2'b01, 99, 0, 1);
    chk("t4_ovf", 64'(overflow), 64'd1);
    step(0, 2'b10, 0, 12, 1);
    step(0, 2'b10, 0, 22, 1);
    idle(3, 1);
    pin_rows("t4");
    chk("t4_ovf_sticky", 64'(overflow), 64'd1);
    step(1, 2'b00, 0, 0, 1);
    chk("t4_ovf_clr", 64'(overflow), 64'd0);
    step(0, 2'b11, 1, 2, 1);
    step(0, 2'b11, 3, 4, 1);
    idle(3, 1);

    // Reset mid-collect
    log_q.delete();
    m_done_cnt = 0;
    step(1, 2'b00, 0, 0, 1);
    step(0, 2'b01, 77, 0, 1);
    reset_n = 1'b0;
    idle(2, 1);
    chk("t5_rst_data", out_data, 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    idle(1, 1);
    chk("t5_no_done", 64'(m_done_cnt), 64'd0);
    skew_tile();
    idle(4, 1);
    pin_rows("t5");

    // Ignored col_valid in IDLE and start in DRAIN
    log_q.delete();
    step(0, 2'b11, 55, 66, 1);
    step(0, 2'b11, 57, 68, 1);
    skew_tile();
    step(1, 2'b11, 88, 89, 0);
    chk("t6_drain_busy", 64'(busy), 64'd1);
    idle(4, 1);
    pin_rows("t6");

    // Randomized tiles
    for (int t = 0; t < 40; t++) begin
      int n;
      step(1, 2'b00, 0, 0, 1);
      n = 0;
      while (m_mode != 0 && n < 400) begin
        if ($urandom_range(0, 99) == 0) begin
          reset_n = 1'b0;
          idle(1, 1);
          reset_n = 1'b1;
        end else begin
          step($urandom_range(0, 7) == 0,
               2'($urandom_range(0, 3)),
               $urandom, $urandom,
               $urandom_range(0, 9) < 7);
        end
        n++;
      end
      idle(1, 1);
      chk("tile_timeout", 64'(busy), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
